// File: rtl/branch_rs.sv
// Branch reservation station: captures pending operands from the ALU and load/store
// broadcast buses and issues at most one ready branch per cycle to the branch unit.
module branch_rs #(
   parameter int ENTRIES = 4,
   parameter int IDX_W   = 2,
   parameter int TAG_W   = 4,
   parameter int OP_W    = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             dispEn,
   input  logic [OP_W-1:0]  dispOp,
   input  logic [31:0]      dispImm,
   input  logic [31:0]      dispPC,
   input  logic [1:0]       dispBNum,
   input  logic             dispValO,
   input  logic [31:0]      dispDataO,
   input  logic [TAG_W-1:0] dispTagO,
   input  logic             dispValT,
   input  logic [31:0]      dispDataT,
   input  logic [TAG_W-1:0] dispTagT,
   input  logic             aluCdbEn,
   input  logic [TAG_W-1:0] aluCdbTag,
   input  logic [31:0]      aluCdbData,
   input  logic             lsCdbEn,
   input  logic [TAG_W-1:0] lsCdbTag,
   input  logic [31:0]      lsCdbData,
   output logic             rsFull,
   output logic             BranchWorkEn,
   output logic [31:0]      operandO,
   output logic [31:0]      operandT,
   output logic [OP_W-1:0]  opCode,
   output logic [31:0]      imm,
   output logic [31:0]      PC,
   output logic [1:0]       bNum
);

   // ALU bus wins when both buses carry the same tag.
   function automatic logic f_hit(input logic [TAG_W-1:0] tag,
                                  input logic a_en, input logic [TAG_W-1:0] a_tag,
                                  input logic l_en, input logic [TAG_W-1:0] l_tag);
      return (a_en && (a_tag == tag)) || (l_en && (l_tag == tag));
   endfunction

   function automatic logic [31:0] f_data(input logic [TAG_W-1:0] tag,
                                          input logic a_en, input logic [TAG_W-1:0] a_tag,
                                          input logic [31:0] a_data, input logic [31:0] l_data);
      return (a_en && (a_tag == tag)) ? a_data : l_data;
   endfunction

   logic [ENTRIES-1:0] r_busy;
   logic [ENTRIES-1:0] r_rdyO;
   logic [ENTRIES-1:0] r_rdyT;
   logic [OP_W-1:0]    r_op    [ENTRIES];
   logic [31:0]        r_imm   [ENTRIES];
   logic [31:0]        r_pc    [ENTRIES];
   logic [1:0]         r_bnum  [ENTRIES];
   logic [31:0]        r_dataO [ENTRIES];
   logic [31:0]        r_dataT [ENTRIES];
   logic [TAG_W-1:0]   r_tagO  [ENTRIES];
   logic [TAG_W-1:0]   r_tagT  [ENTRIES];

   logic [ENTRIES-1:0] w_ready;
   logic [ENTRIES-1:0] w_wakeO;
   logic [ENTRIES-1:0] w_wakeT;
   logic [31:0]        w_wakeDataO [ENTRIES];
   logic [31:0]        w_wakeDataT [ENTRIES];
   logic               w_iss_vld;
   logic [IDX_W-1:0]   w_iss_idx;
   logic               w_free_vld;
   logic [IDX_W-1:0]   w_free_idx;
   logic               w_disp;
   logic               w_dispRdyO;
   logic               w_dispRdyT;
   logic [31:0]        w_dispDataO;
   logic [31:0]        w_dispDataT;

   assign rsFull = &r_busy;
   assign w_disp = dispEn && w_free_vld;

   always_comb begin
      w_dispRdyO  = dispValO || f_hit(dispTagO, aluCdbEn, aluCdbTag, lsCdbEn, lsCdbTag);
      w_dispRdyT  = dispValT || f_hit(dispTagT, aluCdbEn, aluCdbTag, lsCdbEn, lsCdbTag);
      w_dispDataO = dispValO ? dispDataO
                             : f_data(dispTagO, aluCdbEn, aluCdbTag, aluCdbData, lsCdbData);
      w_dispDataT = dispValT ? dispDataT
                             : f_data(dispTagT, aluCdbEn, aluCdbTag, aluCdbData, lsCdbData);
   end

   always_comb begin
      w_iss_vld  = 1'b0;
      w_iss_idx  = '0;
      w_free_vld = 1'b0;
      w_free_idx = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         w_ready[i]     = r_busy[i] && r_rdyO[i] && r_rdyT[i];
         w_wakeO[i]     = r_busy[i] && !r_rdyO[i] &&
                          f_hit(r_tagO[i], aluCdbEn, aluCdbTag, lsCdbEn, lsCdbTag);
         w_wakeT[i]     = r_busy[i] && !r_rdyT[i] &&
                          f_hit(r_tagT[i], aluCdbEn, aluCdbTag, lsCdbEn, lsCdbTag);
         w_wakeDataO[i] = f_data(r_tagO[i], aluCdbEn, aluCdbTag, aluCdbData, lsCdbData);
         w_wakeDataT[i] = f_data(r_tagT[i], aluCdbEn, aluCdbTag, aluCdbData, lsCdbData);
      end
      // Scan downward so the lowest index wins both selections.
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (w_ready[i]) begin
            w_iss_vld = 1'b1;
            w_iss_idx = IDX_W'(i);
         end
         if (!r_busy[i]) begin
            w_free_vld = 1'b1;
            w_free_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy       <= '0;
         r_rdyO       <= '0;
         r_rdyT       <= '0;
         BranchWorkEn <= 1'b0;
         operandO     <= '0;
         operandT     <= '0;
         opCode       <= '0;
         imm          <= '0;
         PC           <= '0;
         bNum         <= '0;
      end else if (flush) begin
         r_busy       <= '0;
         BranchWorkEn <= 1'b0;
      end else begin
         BranchWorkEn <= w_iss_vld;
         if (w_iss_vld) begin
            r_busy[w_iss_idx] <= 1'b0;
            operandO          <= r_dataO[w_iss_idx];
            operandT          <= r_dataT[w_iss_idx];
            opCode            <= r_op[w_iss_idx];
            imm               <= r_imm[w_iss_idx];
            PC                <= r_pc[w_iss_idx];
            bNum              <= r_bnum[w_iss_idx];
         end
         for (int i = 0; i < ENTRIES; i++) begin
            if (w_wakeO[i]) r_rdyO[i] <= 1'b1;
            if (w_wakeT[i]) r_rdyT[i] <= 1'b1;
         end
         // The free slot was idle before this edge, so it never collides with issue or wakeup.
         if (w_disp) begin
            r_busy[w_free_idx] <= 1'b1;
            r_rdyO[w_free_idx] <= w_dispRdyO;
            r_rdyT[w_free_idx] <= w_dispRdyT;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < ENTRIES; i++) begin
         if (w_wakeO[i]) r_dataO[i] <= w_wakeDataO[i];
         if (w_wakeT[i]) r_dataT[i] <= w_wakeDataT[i];
      end
      if (w_disp && !flush) begin
         r_op[w_free_idx]    <= dispOp;
         r_imm[w_free_idx]   <= dispImm;
         r_pc[w_free_idx]    <= dispPC;
         r_bnum[w_free_idx]  <= dispBNum;
         r_dataO[w_free_idx] <= w_dispDataO;
         r_dataT[w_free_idx] <= w_dispDataT;
         r_tagO[w_free_idx]  <= dispTagO;
         r_tagT[w_free_idx]  <= dispTagT;
      end
   end

endmodule

// File: tb/tb_branch_rs.sv
// Directed bench for branch_rs: a slot-level behavioural model checked every cycle,
// plus literal expectations for each scenario.
module tb_branch_rs;
   localparam int ENTRIES = 4;
   localparam int TAG_W   = 4;
   localparam int OP_W    = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             dispEn;
   logic [OP_W-1:0]  dispOp;
   logic [31:0]      dispImm;
   logic [31:0]      dispPC;
   logic [1:0]       dispBNum;
   logic             dispValO;
   logic [31:0]      dispDataO;
   logic [TAG_W-1:0] dispTagO;
   logic             dispValT;
   logic [31:0]      dispDataT;
   logic [TAG_W-1:0] dispTagT;
   logic             aluCdbEn;
   logic [TAG_W-1:0] aluCdbTag;
   logic [31:0]      aluCdbData;
   logic             lsCdbEn;
   logic [TAG_W-1:0] lsCdbTag;
   logic [31:0]      lsCdbData;
   logic             rsFull;
   logic             BranchWorkEn;
   logic [31:0]      operandO;
   logic [31:0]      operandT;
   logic [OP_W-1:0]  opCode;
   logic [31:0]      imm;
   logic [31:0]      PC;
   logic [1:0]       bNum;

   int n_checks = 0;
   int n_err    = 0;

   branch_rs #(.ENTRIES(ENTRIES), .IDX_W(2), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .dispEn(dispEn), .dispOp(dispOp),
      .dispImm(dispImm), .dispPC(dispPC), .dispBNum(dispBNum),
      .dispValO(dispValO), .dispDataO(dispDataO), .dispTagO(dispTagO),
      .dispValT(dispValT), .dispDataT(dispDataT), .dispTagT(dispTagT),
      .aluCdbEn(aluCdbEn), .aluCdbTag(aluCdbTag), .aluCdbData(aluCdbData),
      .lsCdbEn(lsCdbEn), .lsCdbTag(lsCdbTag), .lsCdbData(lsCdbData),
      .rsFull(rsFull), .BranchWorkEn(BranchWorkEn), .operandO(operandO),
      .operandT(operandT), .opCode(opCode), .imm(imm), .PC(PC), .bNum(bNum)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             busy;
      logic             rO;
      logic             rT;
      logic [31:0]      dO;
      logic [31:0]      dT;
      logic [TAG_W-1:0] tO;
      logic [TAG_W-1:0] tT;
      logic [OP_W-1:0]  op;
      logic [31:0]      imm;
      logic [31:0]      pc;
      logic [1:0]       bn;
   } slot_t;

   slot_t            m    [ENTRIES];
   slot_t            mp   [ENTRIES];
   logic             e_work = 1'b0;
   logic [31:0]      e_oO = '0, e_oT = '0, e_imm = '0, e_pc = '0;
   logic [OP_W-1:0]  e_op = '0;
   logic [1:0]       e_bn = '0;
   logic             m_full;
   int               mk, mf;

   function automatic logic snoop_hit(input logic [TAG_W-1:0] t);
      return (aluCdbEn && aluCdbTag == t) || (lsCdbEn && lsCdbTag == t);
   endfunction

   function automatic logic [31:0] snoop_dat(input logic [TAG_W-1:0] t);
      if (aluCdbEn && aluCdbTag == t) return aluCdbData;
      return lsCdbData;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: an instruction pool updated once per clock edge.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) m[i].busy = 1'b0;
         e_work = 1'b0; e_oO = '0; e_oT = '0; e_imm = '0; e_pc = '0; e_op = '0; e_bn = '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) mp[i] = m[i];
         m_full = 1'b1;
         for (int i = 0; i < ENTRIES; i++) if (!mp[i].busy) m_full = 1'b0;
         if (flush) begin
            for (int i = 0; i < ENTRIES; i++) m[i].busy = 1'b0;
            e_work = 1'b0;
         end else begin
            mk = -1;
            for (int i = ENTRIES - 1; i >= 0; i--)
               if (mp[i].busy && mp[i].rO && mp[i].rT) mk = i;
            e_work = (mk >= 0);
            if (mk >= 0) begin
               e_oO = mp[mk].dO; e_oT = mp[mk].dT; e_imm = mp[mk].imm;
               e_pc = mp[mk].pc; e_op = mp[mk].op; e_bn = mp[mk].bn;
               m[mk].busy = 1'b0;
            end
            for (int i = 0; i < ENTRIES; i++) begin
               if (mp[i].busy && !mp[i].rO && snoop_hit(mp[i].tO)) begin
                  m[i].rO = 1'b1; m[i].dO = snoop_dat(mp[i].tO);
               end
               if (mp[i].busy && !mp[i].rT && snoop_hit(mp[i].tT)) begin
                  m[i].rT = 1'b1; m[i].dT = snoop_dat(mp[i].tT);
               end
            end
            if (dispEn && !m_full) begin
               mf = -1;
               for (int i = ENTRIES - 1; i >= 0; i--) if (!mp[i].busy) mf = i;
               m[mf].busy = 1'b1;
               m[mf].op = dispOp; m[mf].imm = dispImm; m[mf].pc = dispPC; m[mf].bn = dispBNum;
               m[mf].tO = dispTagO; m[mf].tT = dispTagT;
               m[mf].rO = dispValO || snoop_hit(dispTagO);
               m[mf].dO = dispValO ? dispDataO : snoop_dat(dispTagO);
               m[mf].rT = dispValT || snoop_hit(dispTagT);
               m[mf].dT = dispValT ? dispDataT : snoop_dat(dispTagT);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic full_exp;
      full_exp = 1'b1;
      for (int i = 0; i < ENTRIES; i++) if (!m[i].busy) full_exp = 1'b0;
      cmp("m_work", 32'(BranchWorkEn), 32'(e_work));
      cmp("m_full", 32'(rsFull), 32'(full_exp));
      cmp("m_opO", operandO, e_oO);
      cmp("m_opT", operandT, e_oT);
      cmp("m_op", 32'(opCode), 32'(e_op));
      cmp("m_imm", imm, e_imm);
      cmp("m_pc", PC, e_pc);
      cmp("m_bn", 32'(bNum), 32'(e_bn));
   end

   task automatic tick();
      @(negedge clk);
      dispEn = 1'b0; aluCdbEn = 1'b0; lsCdbEn = 1'b0; flush = 1'b0;
   endtask

   task automatic disp(input logic [OP_W-1:0] op, input logic [31:0] pc, input logic [31:0] im,
                       input logic [1:0] bn, input logic vO, input logic [31:0] dO,
                       input logic [TAG_W-1:0] tO, input logic vT, input logic [31:0] dT,
                       input logic [TAG_W-1:0] tT);
      dispEn = 1'b1; dispOp = op; dispPC = pc; dispImm = im; dispBNum = bn;
      dispValO = vO; dispDataO = dO; dispTagO = tO;
      dispValT = vT; dispDataT = dT; dispTagT = tT;
   endtask

   task automatic alu(input logic [TAG_W-1:0] t, input logic [31:0] d);
      aluCdbEn = 1'b1; aluCdbTag = t; aluCdbData = d;
   endtask

   task automatic ls(input logic [TAG_W-1:0] t, input logic [31:0] d);
      lsCdbEn = 1'b1; lsCdbTag = t; lsCdbData = d;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; dispEn = 1'b0; dispOp = '0; dispImm = '0; dispPC = '0;
      dispBNum = '0; dispValO = 1'b0; dispDataO = '0; dispTagO = '0; dispValT = 1'b0;
      dispDataT = '0; dispTagT = '0; aluCdbEn = 1'b0; aluCdbTag = '0; aluCdbData = '0;
      lsCdbEn = 1'b0; lsCdbTag = '0; lsCdbData = '0;
      repeat (2) @(negedge clk);
      cmp("rst_work", 32'(BranchWorkEn), 32'd0);
      cmp("rst_full", 32'(rsFull), 32'd0);
      cmp("rst_opO", operandO, 32'd0);
      cmp("rst_pc", PC, 32'd0);
      rst = 1'b1;
      tick();

      // Both operands ready at dispatch
      disp(6'h04, 32'h100, 32'h20, 2'd2, 1'b1, 32'd5, 4'd0, 1'b1, 32'd5, 4'd0);
      tick();
      cmp("t1_pre_work", 32'(BranchWorkEn), 32'd0);
      tick();
      cmp("t1_work", 32'(BranchWorkEn), 32'd1);
      cmp("t1_opO", operandO, 32'd5);
      cmp("t1_opT", operandT, 32'd5);
      cmp("t1_pc", PC, 32'h100);
      cmp("t1_imm", imm, 32'h20);
      cmp("t1_bn", 32'(bNum), 32'd2);
      cmp("t1_op", 32'(opCode), 32'h04);
      tick();
      cmp("t1_post_work", 32'(BranchWorkEn), 32'd0);
      cmp("t1_post_full", 32'(rsFull), 32'd0);

      // O pending on tag 3, woken by ALU bus two cycles later
      disp(6'h05, 32'h200, 32'h40, 2'd1, 1'b0, 32'd0, 4'd3, 1'b1, 32'd7, 4'd0);
      tick();
      tick();
      alu(4'd3, 32'd9);
      tick();
      cmp("t2_hit_work", 32'(BranchWorkEn), 32'd0);
      tick();
      cmp("t2_work", 32'(BranchWorkEn), 32'd1);
      cmp("t2_opO", operandO, 32'd9);
      cmp("t2_opT", operandT, 32'd7);
      cmp("t2_pc", PC, 32'h200);

      // Dispatch bypass from LS bus, then both buses matching
      disp(6'h06, 32'h300, 32'h8, 2'd0, 1'b0, 32'd0, 4'd5, 1'b1, 32'h11, 4'd0);
      ls(4'd5, 32'h44);
      tick();
      cmp("t3_byp_work0", 32'(BranchWorkEn), 32'd0);
      tick();
      cmp("t3_byp_work", 32'(BranchWorkEn), 32'd1);
      cmp("t3_byp_opO", operandO, 32'h44);
      disp(6'h06, 32'h310, 32'h8, 2'd3, 1'b0, 32'd0, 4'd5, 1'b1, 32'h11, 4'd0);
      alu(4'd5, 32'd1);
      ls(4'd5, 32'd2);
      tick();
      tick();
      cmp("t3_prio_work", 32'(BranchWorkEn), 32'd1);
      cmp("t3_prio_opO", operandO, 32'd1);
      tick();

      // Fill all slots with O pending on tags 1..4
      for (int i = 0; i < ENTRIES; i++) begin
         disp(6'h07, 32'h400 + 32'(i * 4), 32'h10, 2'(i), 1'b0, 32'd0, 4'(i + 1),
              1'b1, 32'h70 + 32'(i), 4'd0);
         tick();
      end
      cmp("t4_full", 32'(rsFull), 32'd1);
      disp(6'h08, 32'h555, 32'h0, 2'd0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
      tick();
      cmp("t4_drop_full", 32'(rsFull), 32'd1);
      tick();
      cmp("t4_drop_work", 32'(BranchWorkEn), 32'd0);
      alu(4'd3, 32'h30);
      ls(4'd1, 32'h10);
      tick();
      cmp("t4_wake_work", 32'(BranchWorkEn), 32'd0);
      cmp("t4_wake_full", 32'(rsFull), 32'd1);
      tick();
      cmp("t4_iss0_work", 32'(BranchWorkEn), 32'd1);
      cmp("t4_iss0_pc", PC, 32'h400);
      cmp("t4_iss0_opO", operandO, 32'h10);
      cmp("t4_iss0_full", 32'(rsFull), 32'd0);
      tick();
      cmp("t4_iss2_work", 32'(BranchWorkEn), 32'd1);
      cmp("t4_iss2_pc", PC, 32'h408);
      cmp("t4_iss2_opO", operandO, 32'h30);
      cmp("t4_iss2_opT", operandT, 32'h72);
      tick();
      cmp("t4_idle_work", 32'(BranchWorkEn), 32'd0);

      // Slots 1 and 3 become ready, then flush with a concurrent dispatch
      alu(4'd2, 32'h22);
      ls(4'd4, 32'h44);
      tick();
      flush = 1'b1;
      disp(6'h09, 32'h777, 32'h0, 2'd0, 1'b1, 32'd3, 4'd0, 1'b1, 32'd3, 4'd0);
      tick();
      cmp("t5_flush_work", 32'(BranchWorkEn), 32'd0);
      cmp("t5_flush_full", 32'(rsFull), 32'd0);
      tick();
      cmp("t5_lost_work", 32'(BranchWorkEn), 32'd0);
      tick();
      cmp("t5_lost_work2", 32'(BranchWorkEn), 32'd0);
      disp(6'h0a, 32'h888, 32'h4, 2'd1, 1'b1, 32'h88, 4'd0, 1'b1, 32'h99, 4'd0);
      tick();
      tick();
      cmp("t5_fresh_work", 32'(BranchWorkEn), 32'd1);
      cmp("t5_fresh_pc", PC, 32'h888);
      cmp("t5_fresh_opT", operandT, 32'h99);

      // Asynchronous reset with three pending slots mid-wakeup
      for (int i = 0; i < 3; i++) begin
         disp(6'h0b, 32'h900 + 32'(i * 4), 32'h4, 2'd0, 1'b0, 32'd0, 4'(i + 6),
              1'b1, 32'd1, 4'd0);
         tick();
      end
      alu(4'd6, 32'h66);
      #2 rst = 1'b0;
      #1;
      cmp("t6_work", 32'(BranchWorkEn), 32'd0);
      cmp("t6_full", 32'(rsFull), 32'd0);
      cmp("t6_opO", operandO, 32'd0);
      cmp("t6_opT", operandT, 32'd0);
      cmp("t6_op", 32'(opCode), 32'd0);
      cmp("t6_imm", imm, 32'd0);
      cmp("t6_pc", PC, 32'd0);
      cmp("t6_bn", 32'(bNum), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      alu(4'd7, 32'h77);
      ls(4'd8, 32'h88);
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         cmp("t6_no_issue", 32'(BranchWorkEn), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
